fp_mac8_seq_ctrl: RTL
=====================

Name: fp_mac8_seq_ctrl

Overview:
Sequencer for the team's 8-way operand-select floating-point MAC (ports select[2:0], c, rnd in; z, status out). On a start command it walks select from 0 up to N-1 and feeds each MAC result back as the next c operand. This computes c0 + b*a0 + b*a1 + … + b*a(N-1). It sits between a host or command block and the MAC datapath, and returns the accumulated result with sticky status.

Parameters:
SIG_WIDTH, 23, FP significand width (matches the MAC)
EXP_WIDTH, 8, FP exponent width (matches the MAC)
MAC_LAT, 0, clock cycles from select/c change to valid z/status (0 = combinational MAC)
HALT_ON_INVALID, 1, 1 = abort the sequence when the MAC reports an invalid operation (status[2])

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a sequence; sampled only in IDLE
num_terms_m1  in  3  number of terms minus 1 (0..7 → 1..8 terms), latched on start
init_c  in  SIG_WIDTH+EXP_WIDTH+1  initial accumulator, latched on start
rnd_in  in  3  rounding mode, latched on start
abort  in  1  synchronous cancel of an active sequence
mac_select  out  3  operand index to MAC
mac_c  out  SIG_WIDTH+EXP_WIDTH+1  accumulator operand to MAC
mac_rnd  out  3  rounding mode to MAC
mac_z  in  SIG_WIDTH+EXP_WIDTH+1  MAC result
mac_status  in  8  MAC status (bit 0 zero, 1 inf, 2 invalid, 3 tiny, 4 huge, 5 inexact)
busy  out  1  high in EXEC and DONE
done  out  1  one-cycle pulse when the result is valid
halted  out  1  last sequence ended early (invalid or abort); held until next start
result  out  SIG_WIDTH+EXP_WIDTH+1  final accumulator; held until next start
status_acc  out  8  OR of all captured mac_status values; bit 0 replaced by the last captured status[0]

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is asynchronous and active-high.
- Values on reset:
  - state=IDLE; idx=0; wcnt=0; acc=0.
  - mac_select=0, mac_c=0, mac_rnd=0.
  - busy=0, done=0, halted=0, result=0, status_acc=0.
- States: IDLE, EXEC, DONE.
- IDLE:
  - On start=1: latch N-1, rnd and acc←init_c; clear idx, wcnt, status_acc and halted; go to EXEC.
  - If start and abort are both high, start wins.
- EXEC:
  - mac_select=idx and mac_c=acc are driven from registers and are stable through the term. mac_rnd = latched rnd.
  - wcnt counts 0..MAC_LAT. When wcnt==MAC_LAT, capture the term:
    - acc←mac_z
    - status_acc |= mac_status (bit 0 takes the new value)
    - wcnt←0
  - After a capture: if idx==N-1, go to DONE; otherwise idx←idx+1.
  - Each term therefore takes MAC_LAT+1 cycles. A sequence takes N*(MAC_LAT+1) EXEC cycles plus 1 DONE cycle.
- Invalid halt: if HALT_ON_INVALID=1 and the captured mac_status[2]=1, capture that term, set halted=1 and go to DONE regardless of idx.
- Abort: abort=1 in EXEC sets halted=1 and goes to DONE with no capture that cycle. acc keeps its last captured value.
- DONE: result←acc, done=1 for exactly one cycle, then go to IDLE. busy is deasserted on entry to IDLE.
- start is ignored while busy; it is not queued. abort in IDLE or DONE has no effect.
- idx never wraps. N=8 ends at idx=7 with no overflow.
- Reset asserted mid-sequence returns everything to the reset values immediately. done is not emitted.
- Back-to-back: start may be high in the cycle immediately after done. A new sequence then begins at that edge.

Test Plan:
- N=8, a_i = 1.0..8.0, b=2.0 (0x40000000), init_c=0, rnd=0, MAC_LAT=0 → done 9 cycles after start, result=0x42900000 (72.0), status_acc=0, halted=0; mac_select steps 0..7 one per cycle.
- N=1 (num_terms_m1=0), a0=1.5 (0x3FC00000), b=2.0, init_c=1.0 (0x3F800000) → result=0x40800000 (4.0), done 2 cycles after start.
- MAC_LAT=2, same stimulus as the first test → mac_select holds each index for 3 cycles; done 25 cycles after start; result=0x42900000.
- a3 = +inf, b=0.0, N=8, HALT_ON_INVALID=1 → capture at idx=3, halted=1, status_acc[2]=1, done 5 cycles after start; mac_select never reaches 4.
- abort pulsed on the 3rd EXEC cycle (N=8, LAT=0) → halted=1, result = sum of the first 2 terms, done the next cycle; start pulsed while busy has no effect.
- rst asserted asynchronously mid-EXEC → all outputs at reset values before the next edge, no done pulse; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/fp_mac8_seq_ctrl.sv
// fp_mac8_seq_ctrl: steps an 8-way operand-select FP MAC through N terms, feeding each result back as c
module fp_mac8_seq_ctrl #(
    parameter int SIG_WIDTH       = 23,
    parameter int EXP_WIDTH       = 8,
    parameter int MAC_LAT         = 0,
    parameter int HALT_ON_INVALID = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2:0]                     num_terms_m1,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   init_c,
    input  logic [2:0]                     rnd_in,
    input  logic                           abort,
    output logic [2:0]                     mac_select,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   mac_c,
    output logic [2:0]                     mac_rnd,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   mac_z,
    input  logic [7:0]                     mac_status,
    output logic                           busy,
    output logic                           done,
    output logic                           halted,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   result,
    output logic [7:0]                     status_acc
);
    localparam int W  = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int CW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      idx, nm1, rnd;
    logic [CW-1:0]   wcnt;
    logic [W-1:0]    acc;
    logic            capture, inval, finish;

    assign mac_select = idx;
    assign mac_c      = acc;
    assign mac_rnd    = rnd;
    assign busy       = state != IDLE;
    assign done       = state == DONE;

    // capture decision and next state; abort suppresses the capture of its cycle
    always_comb begin
        capture   = (state == EXEC) && !abort && (wcnt == CW'(MAC_LAT));
        inval     = (HALT_ON_INVALID != 0) && mac_status[2];
        finish    = abort || (capture && (idx == nm1 || inval));
        state_nxt = (state == IDLE) ? (start ? EXEC : IDLE) :
                    (state == DONE) ? IDLE :
                    finish          ? DONE : EXEC;
    end

    // sequencing registers; result is loaded on entry to DONE so it is valid alongside done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            nm1        <= '0;
            rnd        <= '0;
            wcnt       <= '0;
            acc        <= '0;
            halted     <= 1'b0;
            result     <= '0;
            status_acc <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                nm1        <= num_terms_m1;
                rnd        <= rnd_in;
                acc        <= init_c;
                idx        <= '0;
                wcnt       <= '0;
                status_acc <= '0;
                halted     <= 1'b0;
            end
            if (state == EXEC) begin
                if (abort) begin
                    halted <= 1'b1;
                end else if (capture) begin
                    acc        <= mac_z;
                    status_acc <= {status_acc[7:1] | mac_status[7:1], mac_status[0]};
                    wcnt       <= '0;
                    if (inval)
                        halted <= 1'b1;
                    else if (idx != nm1)
                        idx <= idx + 3'd1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                if (finish)
                    result <= capture ? mac_z : acc;
            end
        end
    end
endmodule
